// File: rtl/cpu_ctrl_pkg.sv
// Control codes shared with the ALU decoder, and the mul/div sequencer states.
package cpu_ctrl_pkg;

  typedef enum logic [4:0] {
    CONTROL_AND   = 5'b00000,
    CONTROL_OR    = 5'b00001,
    CONTROL_ADD   = 5'b00010,
    CONTROL_SUB   = 5'b00110,
    CONTROL_SLT   = 5'b00111,
    CONTROL_MULT  = 5'b10000,
    CONTROL_MULTU = 5'b10001,
    CONTROL_DIV   = 5'b10010,
    CONTROL_DIVU  = 5'b10011,
    CONTROL_MTLO  = 5'b10101,
    CONTROL_MTHI  = 5'b10110
  } alu_control_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_iter_core.sv
// Unsigned iteration engine: radix-2 shift-add multiply and restoring divide,
// sharing one double-width accumulator and one operand register.
module muldiv_iter_core #(
  parameter int W    = 32,
  parameter int ITER = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic           load_div,
  input  logic           step_mul,
  input  logic           step_div,
  input  logic [W-1:0]   a_mag,
  input  logic [W-1:0]   b_mag,
  output logic [2*W-1:0] acc,
  output logic           last
);
  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   opnd_q, opnd_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W:0]     sum, sh_hi;
  logic [W-1:0]   dif;
  logic           ge;

  always_comb begin
    // mul: add multiplicand into the upper half when the low bit is set, then shift right
    sum   = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? opnd_q : {W{1'b0}})};
    // div: remainder shifted left by one; the difference fits W bits whenever ge holds
    sh_hi = acc_q[2*W-1:W-1];
    ge    = sh_hi >= {1'b0, opnd_q};
    dif   = sh_hi[W-1:0] - opnd_q;

    acc_d  = acc_q;
    opnd_d = opnd_q;
    cnt_d  = cnt_q;
    if (load) begin
      acc_d  = {{W{1'b0}}, (load_div ? a_mag : b_mag)};
      opnd_d = load_div ? b_mag : a_mag;
      cnt_d  = '0;
    end else if (step_mul) begin
      acc_d = {sum, acc_q[W-1:1]};
      cnt_d = cnt_q + 1'b1;
    end else if (step_div) begin
      acc_d = {(ge ? dif : sh_hi[W-1:0]), acc_q[W-2:0], ge};
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q  <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      cnt_q  <= cnt_d;
    end
  end

  assign acc  = acc_q;
  assign last = cnt_q == CW'(ITER - 1);

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO owner: accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO, sequences the iteration
// core, applies signs in the FIX cycle and writes HI/LO.
module hilo_muldiv_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ITER_CYCLES = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue_valid,
  input  logic [4:0]            alu_control,
  input  logic                  LO_write_enable,
  input  logic                  HI_write_enable,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo,
  output logic                  busy,
  output logic                  done
);
  localparam int W = DATA_WIDTH;

  muldiv_state_t state_q, state_d;

  logic [W-1:0]   hi_q, hi_d, lo_q, lo_d, a_raw_q, a_raw_d;
  logic           done_q, done_d, neg_q, neg_d, rem_neg_q, rem_neg_d;
  logic           div0_q, div0_d, is_div_q, is_div_d;
  logic           core_load, step_mul, step_div, last;
  logic [2*W-1:0] acc, prod_fix;
  logic [W-1:0]   quo_fix, rem_fix, a_mag, b_mag;
  logic           op_mul, op_div, op_signed, sa, sb, b_zero, idle;
  logic           acc_md, acc_lo, acc_hi;

  assign op_mul    = (alu_control == CONTROL_MULT) || (alu_control == CONTROL_MULTU);
  assign op_div    = (alu_control == CONTROL_DIV)  || (alu_control == CONTROL_DIVU);
  assign op_signed = (alu_control == CONTROL_MULT) || (alu_control == CONTROL_DIV);
  assign sa        = op_signed & op_a[W-1];
  assign sb        = op_signed & op_b[W-1];
  // 0x80000000 negates to itself, which is exactly 2^31 read as unsigned
  assign a_mag     = sa ? -op_a : op_a;
  assign b_mag     = sb ? -op_b : op_b;
  assign b_zero    = op_b == '0;
  assign idle      = state_q == IDLE;

  assign acc_md = issue_valid && idle && (op_mul || op_div) && LO_write_enable && HI_write_enable;
  assign acc_lo = issue_valid && idle && (alu_control == CONTROL_MTLO) && LO_write_enable;
  assign acc_hi = issue_valid && idle && (alu_control == CONTROL_MTHI) && HI_write_enable;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (acc_md) state_d = op_div ? (b_zero ? FIX : DIV) : MUL;
      MUL, DIV: if (last) state_d = FIX;
      FIX:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = !idle;
    core_load = acc_md;
    step_mul  = state_q == MUL;
    step_div  = state_q == DIV;
  end

  muldiv_iter_core #(
    .W    (W),
    .ITER (ITER_CYCLES)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (core_load),
    .load_div (op_div),
    .step_mul (step_mul),
    .step_div (step_div),
    .a_mag    (a_mag),
    .b_mag    (b_mag),
    .acc      (acc),
    .last     (last)
  );

  assign prod_fix = neg_q ? -acc : acc;
  assign quo_fix  = neg_q ? -acc[W-1:0] : acc[W-1:0];
  assign rem_fix  = rem_neg_q ? -acc[2*W-1:W] : acc[2*W-1:W];

  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    a_raw_d   = a_raw_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    div0_d    = div0_q;
    is_div_d  = is_div_q;
    done_d    = state_q == FIX;
    if (acc_md) begin
      neg_d     = sa ^ sb;
      rem_neg_d = sa;
      div0_d    = op_div && b_zero;
      is_div_d  = op_div;
      a_raw_d   = op_a;
    end
    if (acc_lo) lo_d = op_a;
    if (acc_hi) hi_d = op_a;
    if (state_q == FIX) begin
      if (div0_q) begin
        lo_d = '1;
        hi_d = a_raw_q;
      end else if (is_div_q) begin
        lo_d = quo_fix;
        hi_d = rem_fix;
      end else begin
        {hi_d, lo_d} = prod_fix;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q      <= '0;
      lo_q      <= '0;
      a_raw_q   <= '0;
      done_q    <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      is_div_q  <= 1'b0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      a_raw_q   <= a_raw_d;
      done_q    <= done_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      div0_q    <= div0_d;
      is_div_q  <= is_div_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign done = done_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Bench for hilo_muldiv_unit: directed cases plus random mul/div against an
// arithmetic reference model; HI/LO expectations tracked in m_hi/m_lo.
module tb_hilo_muldiv_unit;
  localparam logic [4:0] OP_MULT  = 5'b10000;
  localparam logic [4:0] OP_MULTU = 5'b10001;
  localparam logic [4:0] OP_DIV   = 5'b10010;
  localparam logic [4:0] OP_DIVU  = 5'b10011;
  localparam logic [4:0] OP_MTLO  = 5'b10101;
  localparam logic [4:0] OP_MTHI  = 5'b10110;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic [4:0]  alu_control;
  logic        LO_write_enable, HI_write_enable;
  logic [31:0] op_a, op_b;
  logic [31:0] hi, lo;
  logic        busy, done;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  hilo_muldiv_unit #(.DATA_WIDTH(32), .ITER_CYCLES(32)) dut (
    .clk             (clk),
    .reset           (rst_n),
    .issue_valid     (issue_valid),
    .alu_control     (alu_control),
    .LO_write_enable (LO_write_enable),
    .HI_write_enable (HI_write_enable),
    .op_a            (op_a),
    .op_b            (op_b),
    .hi              (hi),
    .lo              (lo),
    .busy            (busy),
    .done            (done)
  );

  // {hi, lo} computed with plain 64-bit arithmetic
  function automatic logic [63:0] ref_md(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = '0;
    case (op)
      OP_MULT:  res = sa * sb;
      OP_MULTU: res = {32'h0, a} * {32'h0, b};
      OP_DIV: begin
        if (b == 32'h0) res = {a, 32'hFFFFFFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      OP_DIVU:  res = (b == 32'h0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
      default:  res = '0;
    endcase
    return res;
  endfunction

  // Issues one instruction and waits (bounded) for done; ends on the done-cycle negedge.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic lwe, input logic hwe, output int bcyc, output bit got);
    alu_control = op; op_a = a; op_b = b;
    LO_write_enable = lwe; HI_write_enable = hwe; issue_valid = 1'b1;
    @(posedge clk); #1 issue_valid = 1'b0;
    bcyc = 0; got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; break; end
      if (busy) bcyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; issue_valid = 1'b0; alu_control = '0; op_a = '0; op_b = '0;
    LO_write_enable = 1'b0; HI_write_enable = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (hi !== 32'h0)  begin n_bad++; $display("FAIL reset_hi got %h exp 0", hi); end
    n_cmp++; if (lo !== 32'h0)  begin n_bad++; $display("FAIL reset_lo got %h exp 0", lo); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b exp 0", done); end
    rst_n = 1'b1;
    @(negedge clk);
    m_hi = '0; m_lo = '0;
  endtask

  task automatic test_mult();
    int bc; bit got;
    run_op(OP_MULT, 32'hFFFFFFFD, 32'd7, 1'b1, 1'b1, bc, got);
    n_cmp++; if (got !== 1'b1)      begin n_bad++; $display("FAIL mult_done got %b exp 1", got); end
    n_cmp++; if (bc != 33)          begin n_bad++; $display("FAIL mult_busy_cycles got %0d exp 33", bc); end
    n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL mult_busy_at_done got %b exp 0", busy); end
    n_cmp++; if (hi !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL mult_hi got %h exp ffffffff", hi); end
    n_cmp++; if (lo !== 32'hFFFFFFEB) begin n_bad++; $display("FAIL mult_lo got %h exp ffffffeb", lo); end
    m_hi = 32'hFFFFFFFF; m_lo = 32'hFFFFFFEB;
    @(negedge clk);
    n_cmp++; if (done !== 1'b0)     begin n_bad++; $display("FAIL mult_done_pulse got %b exp 0", done); end
    n_cmp++; if (lo !== m_lo)       begin n_bad++; $display("FAIL mult_lo_hold got %h exp %h", lo, m_lo); end
  endtask

  task automatic test_back_to_back();
    int bc; bit got;
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, bc, got);
    n_cmp++; if (got !== 1'b1 || bc != 33) begin n_bad++; $display("FAIL b2b_first_timing got done=%b busy=%0d exp 1/33", got, bc); end
    n_cmp++; if (hi !== 32'hFFFFFFFE) begin n_bad++; $display("FAIL b2b_first_hi got %h exp fffffffe", hi); end
    n_cmp++; if (lo !== 32'h00000001) begin n_bad++; $display("FAIL b2b_first_lo got %h exp 00000001", lo); end
    run_op(OP_MULTU, 32'h00010000, 32'h00010000, 1'b1, 1'b1, bc, got);
    n_cmp++; if (got !== 1'b1 || bc != 33) begin n_bad++; $display("FAIL b2b_second_timing got done=%b busy=%0d exp 1/33", got, bc); end
    n_cmp++; if (hi !== 32'h1) begin n_bad++; $display("FAIL b2b_second_hi got %h exp 1", hi); end
    n_cmp++; if (lo !== 32'h0) begin n_bad++; $display("FAIL b2b_second_lo got %h exp 0", lo); end
    m_hi = 32'h1; m_lo = 32'h0;
  endtask

  task automatic test_div();
    int bc; bit got;
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b1, 1'b1, bc, got);
    n_cmp++; if (got !== 1'b1 || bc != 33) begin n_bad++; $display("FAIL div_timing got done=%b busy=%0d exp 1/33", got, bc); end
    n_cmp++; if (lo !== 32'hFFFFFFFD) begin n_bad++; $display("FAIL div_lo got %h exp fffffffd", lo); end
    n_cmp++; if (hi !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL div_hi got %h exp ffffffff", hi); end
    run_op(OP_DIVU, 32'd100, 32'd7, 1'b1, 1'b1, bc, got);
    n_cmp++; if (got !== 1'b1 || bc != 33) begin n_bad++; $display("FAIL divu_timing got done=%b busy=%0d exp 1/33", got, bc); end
    n_cmp++; if (lo !== 32'd14) begin n_bad++; $display("FAIL divu_lo got %h exp 0000000e", lo); end
    n_cmp++; if (hi !== 32'd2)  begin n_bad++; $display("FAIL divu_hi got %h exp 00000002", hi); end
    m_hi = 32'd2; m_lo = 32'd14;
  endtask

  task automatic test_div_edges();
    int bc; bit got;
    run_op(OP_DIVU, 32'd5, 32'd0, 1'b1, 1'b1, bc, got);
    n_cmp++; if (got !== 1'b1 || bc != 1) begin n_bad++; $display("FAIL div0_timing got done=%b busy=%0d exp 1/1", got, bc); end
    n_cmp++; if (lo !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL div0_lo got %h exp ffffffff", lo); end
    n_cmp++; if (hi !== 32'd5) begin n_bad++; $display("FAIL div0_hi got %h exp 00000005", hi); end
    run_op(OP_DIV, 32'hFFFFFF00, 32'd0, 1'b1, 1'b1, bc, got);
    n_cmp++; if (got !== 1'b1 || bc != 1) begin n_bad++; $display("FAIL sdiv0_timing got done=%b busy=%0d exp 1/1", got, bc); end
    n_cmp++; if (hi !== 32'hFFFFFF00) begin n_bad++; $display("FAIL sdiv0_hi_raw got %h exp ffffff00", hi); end
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, bc, got);
    n_cmp++; if (got !== 1'b1 || bc != 33) begin n_bad++; $display("FAIL divwrap_timing got done=%b busy=%0d exp 1/33", got, bc); end
    n_cmp++; if (lo !== 32'h80000000) begin n_bad++; $display("FAIL divwrap_lo got %h exp 80000000", lo); end
    n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL divwrap_hi got %h exp 0", hi); end
    m_hi = 32'h0; m_lo = 32'h80000000;
  endtask

  task automatic test_mt();
    logic [4:0]  ops [3];
    logic [1:0]  ens [3];
    alu_control = OP_MTHI; op_a = 32'h12345678; op_b = '0;
    LO_write_enable = 1'b0; HI_write_enable = 1'b1; issue_valid = 1'b1;
    @(posedge clk); #1 issue_valid = 1'b0;
    @(negedge clk);
    m_hi = 32'h12345678;
    n_cmp++; if (hi !== m_hi)   begin n_bad++; $display("FAIL mthi_hi got %h exp %h", hi, m_hi); end
    n_cmp++; if (lo !== m_lo)   begin n_bad++; $display("FAIL mthi_lo got %h exp %h", lo, m_lo); end
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL mthi_flags got done=%b busy=%b exp 0/0", done, busy); end
    // ignored: mul missing HI enable, unused code, MTLO with only HI enable
    ops[0] = OP_MULT;  ens[0] = 2'b10;
    ops[1] = 5'b10100; ens[1] = 2'b11;
    ops[2] = OP_MTLO;  ens[2] = 2'b01;
    for (int k = 0; k < 3; k++) begin
      alu_control = ops[k]; op_a = 32'hCAFEF00D; op_b = 32'd3;
      LO_write_enable = ens[k][1]; HI_write_enable = ens[k][0]; issue_valid = 1'b1;
      @(posedge clk); #1 issue_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo)
        begin n_bad++; $display("FAIL ignored_%0d got busy=%b hi=%h lo=%h exp 0/%h/%h", k, busy, hi, lo, m_hi, m_lo); end
    end
  endtask

  task automatic test_mt_during_busy();
    bit got; int bc;
    alu_control = OP_DIV; op_a = 32'hFFFFFF9C; op_b = 32'd7;
    LO_write_enable = 1'b1; HI_write_enable = 1'b1; issue_valid = 1'b1;
    @(posedge clk); #1 issue_valid = 1'b0;
    repeat (5) @(negedge clk);
    alu_control = OP_MTLO; op_a = 32'hDEADBEEF; LO_write_enable = 1'b1; HI_write_enable = 1'b0; issue_valid = 1'b1;
    @(negedge clk);
    issue_valid = 1'b0;
    n_cmp++; if (lo !== m_lo) begin n_bad++; $display("FAIL mtlo_busy_hold got %h exp %h", lo, m_lo); end
    got = 1'b0; bc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; break; end
      bc++;
    end
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL mtlo_busy_done got %b exp 1 after %0d cycles", got, bc); end
    n_cmp++; if (lo !== 32'hFFFFFFF2) begin n_bad++; $display("FAIL mtlo_busy_lo got %h exp fffffff2", lo); end
    n_cmp++; if (hi !== 32'hFFFFFFFE) begin n_bad++; $display("FAIL mtlo_busy_hi got %h exp fffffffe", hi); end
    m_hi = 32'hFFFFFFFE; m_lo = 32'hFFFFFFF2;
  endtask

  task automatic test_reset_mid();
    int seen, bc; bit got;
    alu_control = OP_MULT; op_a = 32'h00001234; op_b = 32'h00005678;
    LO_write_enable = 1'b1; HI_write_enable = 1'b1; issue_valid = 1'b1;
    @(posedge clk); #1 issue_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %b exp 0", busy); end
    n_cmp++; if (hi !== 32'h0 || lo !== 32'h0) begin n_bad++; $display("FAIL rstmid_hilo got %h/%h exp 0/0", hi, lo); end
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL rstmid_no_done got %0d active cycles exp 0", seen); end
    run_op(OP_MULTU, 32'd3, 32'd4, 1'b1, 1'b1, bc, got);
    n_cmp++; if (got !== 1'b1 || bc != 33) begin n_bad++; $display("FAIL rstmid_after_timing got done=%b busy=%0d exp 1/33", got, bc); end
    n_cmp++; if (lo !== 32'd12 || hi !== 32'd0) begin n_bad++; $display("FAIL rstmid_after_result got %h/%h exp 0/0000000c", hi, lo); end
    m_hi = 32'd0; m_lo = 32'd12;
  endtask

  task automatic test_random();
    logic [31:0] edges [5];
    logic [31:0] a, b;
    logic [4:0]  op;
    logic [63:0] exp;
    int bc, want; bit got;
    edges[0] = 32'h0; edges[1] = 32'h1; edges[2] = 32'hFFFFFFFF;
    edges[3] = 32'h80000000; edges[4] = 32'h7FFFFFFF;
    for (int n = 0; n < 40; n++) begin
      op = OP_MULT + 5'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: begin a = $urandom; b = $urandom; end
        1: begin a = $urandom_range(0, 1000); b = $urandom_range(0, 20); end
        2: begin a = edges[$urandom_range(0, 4)]; b = edges[$urandom_range(0, 4)]; end
        default: begin a = $urandom; b = $urandom_range(0, 255) - 128; end
      endcase
      exp  = ref_md(op, a, b);
      want = ((op == OP_DIV || op == OP_DIVU) && b == 32'h0) ? 1 : 33;
      run_op(op, a, b, 1'b1, 1'b1, bc, got);
      n_cmp++; if (got !== 1'b1 || bc != want)
        begin n_bad++; $display("FAIL rand_timing op=%b a=%h b=%h got done=%b busy=%0d exp 1/%0d", op, a, b, got, bc, want); end
      n_cmp++; if ({hi, lo} !== exp)
        begin n_bad++; $display("FAIL rand_result op=%b a=%h b=%h got %h_%h exp %h", op, a, b, hi, lo, exp); end
      m_hi = exp[63:32]; m_lo = exp[31:0];
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_back_to_back();
    test_div();
    test_div_edges();
    test_mt();
    test_mt_during_busy();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
